reg_writeback_unit: RTL and testbench

Writer side of the processor's 32x32 register file. Merges single-cycle ALU results with variable-latency load completions. Drives the register file's single write port (write_reg / write_data / write_enable) from registered outputs. Keeps a pending-write scoreboard so decode can stall on RAW hazards.

---
 rtl/reg_writeback_unit_if.sv | 55 +++++
 rtl/reg_writeback_unit.sv | 120 ++++++++++++
 tb/tb_reg_writeback_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_unit_if.sv
// Write-back bus bundle: ALU and load result inputs, issue tracking, register-file write port and scoreboard.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface reg_writeback_unit_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0]     alu_data;
  logic                  load_valid;
  logic                  load_ready;
  logic [REG_ADDR_W-1:0] load_reg;
  logic [DATA_W-1:0]     load_data;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_reg;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic [NUM_REGS-1:0]   busy;
  logic                  wb_idle;
`ifdef WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] read_reg_1;
  logic [REG_ADDR_W-1:0] read_reg_2;
  logic [DATA_W-1:0]     rf_data_1;
  logic [DATA_W-1:0]     rf_data_2;
  logic [DATA_W-1:0]     fwd_data_1;
  logic [DATA_W-1:0]     fwd_data_2;
`endif

  modport master (
    output alu_valid, alu_reg, alu_data,
    output load_valid, load_reg, load_data,
    output issue_valid, issue_reg,
    input  load_ready, write_enable, write_reg, write_data, busy, wb_idle
`ifdef WB_BYPASS_EN
    ,
    output read_reg_1, read_reg_2, rf_data_1, rf_data_2,
    input  fwd_data_1, fwd_data_2
`endif
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  load_valid, load_reg, load_data,
    input  issue_valid, issue_reg,
    output load_ready, write_enable, write_reg, write_data, busy, wb_idle
`ifdef WB_BYPASS_EN
    ,
    input  read_reg_1, read_reg_2, rf_data_1, rf_data_2,
    output fwd_data_1, fwd_data_2
`endif
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// Register-file writer: ALU results take priority over a load-completion FIFO; keeps a RAW scoreboard.
// Define WB_BYPASS_EN to add write-port forwarding and earlier scoreboard clear.
module reg_writeback_unit #(
  parameter int unsigned LOAD_FIFO_DEPTH = 2,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned REG_ADDR_W      = 5
) (
  input logic                 clock,
  input logic                 reset_n,
  reg_writeback_unit_if.slave wb
);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam int unsigned PTR_W    = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;

  logic [REG_ADDR_W-1:0] fifo_reg_q  [LOAD_FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data_q [LOAD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_REGS-1:0]   set_mask, clr_mask;
  logic                  fifo_empty, push, pop;
  logic                  sel_valid;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0]     sel_data;

  assign fifo_empty    = (count_q == '0);
  assign wb.load_ready = (count_q < CNT_W'(LOAD_FIFO_DEPTH)) && reset_n;
  assign push          = wb.load_valid && wb.load_ready;
  assign pop           = !wb.alu_valid && !fifo_empty;

  // ALU wins; FIFO head is consumed only on cycles with no ALU result.
  always_comb begin
    sel_valid = 1'b0;
    sel_reg   = '0;
    sel_data  = '0;
    if (wb.alu_valid) begin
      sel_valid = 1'b1;
      sel_reg   = wb.alu_reg;
      sel_data  = wb.alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_reg   = fifo_reg_q[rd_ptr_q];
      sel_data  = fifo_data_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    we_d     = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    set_mask = '0;
    clr_mask = '0;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (sel_valid) begin
      wreg_d  = sel_reg;
      wdata_d = sel_data;
      we_d    = (sel_reg != '0);
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      set_mask[i] = wb.issue_valid && (wb.issue_reg == REG_ADDR_W'(i));
`ifdef WB_BYPASS_EN
      clr_mask[i] = we_d && (wreg_d == REG_ADDR_W'(i));
`else
      clr_mask[i] = we_q && (wreg_q == REG_ADDR_W'(i));
`endif
    end
    // Set after clear so a same-edge issue keeps the bit.
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  // Payload storage needs no reset; validity lives in the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= wb.load_reg;
      fifo_data_q[wr_ptr_q] <= wb.load_data;
    end
  end

  assign wb.write_enable = we_q;
  assign wb.write_reg    = wreg_q;
  assign wb.write_data   = wdata_q;
  assign wb.busy         = busy_q;
  assign wb.wb_idle      = fifo_empty && !we_q;

`ifdef WB_BYPASS_EN
  assign wb.fwd_data_1 = (we_q && (wreg_q == wb.read_reg_1) && (wb.read_reg_1 != '0))
                         ? wdata_q : wb.rf_data_1;
  assign wb.fwd_data_2 = (we_q && (wreg_q == wb.read_reg_2) && (wb.read_reg_2 != '0))
                         ? wdata_q : wb.rf_data_2;
`endif
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit; builds with or without WB_BYPASS_EN.
module tb_reg_writeback_unit;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  reg_writeback_unit_if #(.DATA_W(32), .REG_ADDR_W(5)) wb_if ();

  reg_writeback_unit #(
    .LOAD_FIFO_DEPTH(2),
    .DATA_W         (32),
    .REG_ADDR_W     (5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .wb     (wb_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_if.alu_valid   = 1'b0;
    wb_if.alu_reg     = '0;
    wb_if.alu_data    = '0;
    wb_if.load_valid  = 1'b0;
    wb_if.load_reg    = '0;
    wb_if.load_data   = '0;
    wb_if.issue_valid = 1'b0;
    wb_if.issue_reg   = '0;
`ifdef WB_BYPASS_EN
    wb_if.read_reg_1  = '0;
    wb_if.read_reg_2  = '0;
    wb_if.rf_data_1   = '0;
    wb_if.rf_data_2   = '0;
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if (wb_if.write_enable !== 1'b0) begin
      $display("FAIL reset_we: got %b expected 0", wb_if.write_enable); errors++;
    end
    checks++;
    if (wb_if.write_reg !== 5'd0 || wb_if.write_data !== 32'd0) begin
      $display("FAIL reset_wr: got reg %0d data %h expected 0/0", wb_if.write_reg, wb_if.write_data); errors++;
    end
    checks++;
    if (wb_if.busy !== 32'd0) begin
      $display("FAIL reset_busy: got %h expected 0", wb_if.busy); errors++;
    end
    checks++;
    if (wb_if.load_ready !== 1'b0) begin
      $display("FAIL reset_ready: got %b expected 0", wb_if.load_ready); errors++;
    end
    checks++;
    if (wb_if.wb_idle !== 1'b1) begin
      $display("FAIL reset_idle: got %b expected 1", wb_if.wb_idle); errors++;
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (wb_if.load_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b expected 1", wb_if.load_ready); errors++;
    end
  endtask

  task automatic test_alu_write();
    wb_if.alu_valid = 1'b1;
    wb_if.alu_reg   = 5'd5;
    wb_if.alu_data  = 32'h0000_1234;
    step();
    wb_if.alu_valid = 1'b0;
    checks++;
    if (wb_if.write_enable !== 1'b1 || wb_if.write_reg !== 5'd5 || wb_if.write_data !== 32'h0000_1234) begin
      $display("FAIL alu_write: got we %b reg %0d data %h expected 1/5/00001234",
               wb_if.write_enable, wb_if.write_reg, wb_if.write_data); errors++;
    end
    checks++;
    if (wb_if.wb_idle !== 1'b0) begin
      $display("FAIL alu_busy_idle: got %b expected 0", wb_if.wb_idle); errors++;
    end
    step();
    checks++;
    if (wb_if.write_enable !== 1'b0 || wb_if.wb_idle !== 1'b1 || wb_if.write_reg !== 5'd5) begin
      $display("FAIL alu_after: got we %b idle %b reg %0d expected 0/1/5",
               wb_if.write_enable, wb_if.wb_idle, wb_if.write_reg); errors++;
    end
  endtask

  task automatic test_r0();
    wb_if.alu_valid = 1'b1;
    wb_if.alu_reg   = 5'd0;
    wb_if.alu_data  = 32'hDEAD_BEEF;
    step();
    wb_if.alu_valid = 1'b0;
    checks++;
    if (wb_if.write_enable !== 1'b0 || wb_if.write_data !== 32'hDEAD_BEEF) begin
      $display("FAIL r0_alu: got we %b data %h expected 0/deadbeef", wb_if.write_enable, wb_if.write_data); errors++;
    end
    wb_if.load_valid = 1'b1;
    wb_if.load_reg   = 5'd0;
    wb_if.load_data  = 32'h0000_0077;
    step();
    wb_if.load_valid = 1'b0;
    checks++;
    if (wb_if.write_enable !== 1'b0 || wb_if.wb_idle !== 1'b0) begin
      $display("FAIL r0_load_queued: got we %b idle %b expected 0/0", wb_if.write_enable, wb_if.wb_idle); errors++;
    end
    step();
    checks++;
    if (wb_if.write_enable !== 1'b0 || wb_if.wb_idle !== 1'b1 || wb_if.busy !== 32'd0) begin
      $display("FAIL r0_load_drain: got we %b idle %b busy %h expected 0/1/0",
               wb_if.write_enable, wb_if.wb_idle, wb_if.busy); errors++;
    end
  endtask

  task automatic test_contention();
    logic       av [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] ar [6] = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0};
    logic       lv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] lr [6] = '{5'd7, 5'd8, 5'd9, 5'd9, 5'd9, 5'd0};
    logic       rdy[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] er [6] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd8, 5'd9};
    logic [31:0] ld [6];
    logic [31:0] ed [6];
    ld = '{32'hA, 32'hB, 32'hC, 32'hC, 32'hC, 32'h0};
    ed = '{32'h101, 32'h102, 32'h103, 32'hA, 32'hB, 32'hC};
    for (int c = 0; c < 6; c++) begin
      wb_if.alu_valid  = av[c];
      wb_if.alu_reg    = ar[c];
      wb_if.alu_data   = 32'h100 + 32'(c + 1);
      wb_if.load_valid = lv[c];
      wb_if.load_reg   = lr[c];
      wb_if.load_data  = ld[c];
      #1;
      checks++;
      if (wb_if.load_ready !== rdy[c]) begin
        $display("FAIL contend_ready[%0d]: got %b expected %b", c, wb_if.load_ready, rdy[c]); errors++;
      end
      step();
      checks++;
      if (wb_if.write_enable !== 1'b1 || wb_if.write_reg !== er[c] || wb_if.write_data !== ed[c]) begin
        $display("FAIL contend_write[%0d]: got we %b reg %0d data %h expected 1/%0d/%h",
                 c, wb_if.write_enable, wb_if.write_reg, wb_if.write_data, er[c], ed[c]); errors++;
      end
    end
    idle_inputs();
    step();
    checks++;
    if (wb_if.write_enable !== 1'b0 || wb_if.wb_idle !== 1'b1) begin
      $display("FAIL contend_drain: got we %b idle %b expected 0/1", wb_if.write_enable, wb_if.wb_idle); errors++;
    end
  endtask

  task automatic test_scoreboard();
    wb_if.issue_valid = 1'b1;
    wb_if.issue_reg   = 5'd9;
    step();
    wb_if.issue_valid = 1'b0;
    checks++;
    if (wb_if.busy !== 32'h0000_0200) begin
      $display("FAIL sb_set: got %h expected 00000200", wb_if.busy); errors++;
    end
    wb_if.alu_valid = 1'b1;
    wb_if.alu_reg   = 5'd9;
    wb_if.alu_data  = 32'h99;
    step();
    wb_if.alu_valid = 1'b0;
    checks++;
`ifdef WB_BYPASS_EN
    if (wb_if.busy[9] !== 1'b0) begin
      $display("FAIL sb_clear_early: got %b expected 0", wb_if.busy[9]); errors++;
    end
`else
    if (wb_if.busy[9] !== 1'b1) begin
      $display("FAIL sb_hold_during_write: got %b expected 1", wb_if.busy[9]); errors++;
    end
`endif
    step();
    checks++;
    if (wb_if.busy !== 32'd0) begin
      $display("FAIL sb_cleared: got %h expected 0", wb_if.busy); errors++;
    end
    // Re-issue r9 on exactly the edge that retires the earlier write.
    wb_if.issue_valid = 1'b1;
    wb_if.issue_reg   = 5'd9;
    step();
    wb_if.issue_valid = 1'b0;
    wb_if.alu_valid   = 1'b1;
    wb_if.alu_reg     = 5'd9;
    wb_if.alu_data    = 32'h9A;
`ifdef WB_BYPASS_EN
    wb_if.issue_valid = 1'b1;
    step();
    wb_if.alu_valid   = 1'b0;
    wb_if.issue_valid = 1'b0;
`else
    step();
    wb_if.alu_valid   = 1'b0;
    wb_if.issue_valid = 1'b1;
    step();
    wb_if.issue_valid = 1'b0;
`endif
    checks++;
    if (wb_if.busy[9] !== 1'b1) begin
      $display("FAIL sb_set_wins: got %b expected 1", wb_if.busy[9]); errors++;
    end
    wb_if.issue_valid = 1'b1;
    wb_if.issue_reg   = 5'd0;
    step();
    wb_if.issue_valid = 1'b0;
    checks++;
    if (wb_if.busy !== 32'h0000_0200) begin
      $display("FAIL sb_r0_issue: got %h expected 00000200", wb_if.busy); errors++;
    end
  endtask

  task automatic test_reset_mid();
    wb_if.alu_valid   = 1'b1;
    wb_if.alu_reg     = 5'd1;
    wb_if.alu_data    = 32'h1;
    wb_if.load_valid  = 1'b1;
    wb_if.load_reg    = 5'd10;
    wb_if.load_data   = 32'h10;
    wb_if.issue_valid = 1'b1;
    wb_if.issue_reg   = 5'd12;
    step();
    wb_if.issue_valid = 1'b0;
    wb_if.alu_reg     = 5'd2;
    wb_if.alu_data    = 32'h2;
    wb_if.load_reg    = 5'd11;
    wb_if.load_data   = 32'h11;
    step();
    idle_inputs();
    checks++;
    if (wb_if.write_enable !== 1'b1 || wb_if.load_ready !== 1'b0 || wb_if.busy[12] !== 1'b1) begin
      $display("FAIL mid_prefill: got we %b ready %b busy12 %b expected 1/0/1",
               wb_if.write_enable, wb_if.load_ready, wb_if.busy[12]); errors++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (wb_if.load_ready !== 1'b0) begin
      $display("FAIL mid_ready_in_reset: got %b expected 0", wb_if.load_ready); errors++;
    end
    step();
    checks++;
    if (wb_if.write_enable !== 1'b0 || wb_if.busy !== 32'd0 || wb_if.wb_idle !== 1'b1) begin
      $display("FAIL mid_reset_state: got we %b busy %h idle %b expected 0/0/1",
               wb_if.write_enable, wb_if.busy, wb_if.wb_idle); errors++;
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (wb_if.load_ready !== 1'b1) begin
      $display("FAIL mid_ready_after: got %b expected 1", wb_if.load_ready); errors++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (wb_if.write_enable !== 1'b0) begin
        $display("FAIL mid_stale_write[%0d]: got we %b reg %0d expected 0", c, wb_if.write_enable, wb_if.write_reg); errors++;
      end
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    wb_if.alu_valid = 1'b1;
    wb_if.alu_reg   = 5'd4;
    wb_if.alu_data  = 32'h55;
    step();
    wb_if.alu_valid  = 1'b0;
    wb_if.read_reg_1 = 5'd4;
    wb_if.rf_data_1  = 32'h11;
    wb_if.read_reg_2 = 5'd0;
    wb_if.rf_data_2  = 32'h22;
    #1;
    checks++;
    if (wb_if.fwd_data_1 !== 32'h55 || wb_if.fwd_data_2 !== 32'h22) begin
      $display("FAIL bypass_hit: got %h/%h expected 00000055/00000022", wb_if.fwd_data_1, wb_if.fwd_data_2); errors++;
    end
    step();
    checks++;
    if (wb_if.fwd_data_1 !== 32'h11) begin
      $display("FAIL bypass_idle: got %h expected 00000011", wb_if.fwd_data_1); errors++;
    end
    idle_inputs();
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alu_write();
    test_r0();
    test_contention();
    test_scoreboard();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
